// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the multi-cycle ALU execute unit: operation codes
// (same encoding as the ALU control decoder), FSM states and default widths.
package alu_exec_unit_pkg;

    localparam int DATA_WIDTH_DEF  = 32;
    localparam int SHAMT_WIDTH_DEF = 5;

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_NOR     = 4'd2;
    localparam logic [3:0] OP_ADD     = 4'd3;
    localparam logic [3:0] OP_SUB     = 4'd4;
    localparam logic [3:0] OP_LUI     = 4'd5;
    localparam logic [3:0] OP_SLL     = 4'd6;
    localparam logic [3:0] OP_SRL     = 4'd7;
    localparam logic [3:0] OP_ILLEGAL = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle ALU datapath: result plus signed-overflow and illegal-op flags.
// Shift ops pass B through; the top level iterates the actual shifting.
module alu_exec_comb
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [3:0]            alu_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  overflow_o,
    output logic                  illegal_o
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (alu_op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_NOR: result_o = ~(a_i | b_i);
            OP_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            OP_SUB: begin
                // Subtraction adds ~B, so overflow needs the operand signs to differ.
                result_o   = diff;
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            OP_LUI:         result_o = {b_i[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_SLL, OP_SRL: result_o = b_i;
            default:        illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: one-cycle ALU ops, bit-serial SLL/SRL, and
// valid/ready handshakes on both sides so the datapath controller can stall.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SHAMT_WIDTH = SHAMT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             alu_op,
    input  logic [DATA_WIDTH-1:0]  a_data,
    input  logic [DATA_WIDTH-1:0]  b_data,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   zero,
    output logic                   overflow,
    output logic                   illegal_op,
    output logic [1:0]             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE.

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   zero_q, zero_d;
    logic                   ovf_q, ovf_d;
    logic                   ill_q, ill_d;
    logic                   shl_q, shl_d;

    logic [DATA_WIDTH-1:0]  comb_result;
    logic                   comb_ovf;
    logic                   comb_ill;
    logic                   is_shift;

    alu_exec_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
        .alu_op_i   (alu_op),
        .a_i        (a_data),
        .b_i        (b_data),
        .result_o   (comb_result),
        .overflow_o (comb_ovf),
        .illegal_o  (comb_ill)
    );

    assign is_shift = ((alu_op == OP_SLL) || (alu_op == OP_SRL)) && (shamt != '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        shl_d    = shl_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_shift) begin
                        result_d = b_data;
                        cnt_d    = shamt;
                        shl_d    = (alu_op == OP_SLL);
                        ovf_d    = 1'b0;
                        ill_d    = 1'b0;
                        state_d  = ST_SHIFT;
                    end else begin
                        result_d = comb_result;
                        ovf_d    = comb_ovf;
                        ill_d    = comb_ill;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = shl_q ? (result_q << 1) : (result_q >> 1);
                cnt_d    = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leaving DONE never overlaps with a new accept.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            shl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            shl_q    <= shl_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign overflow   = ovf_q;
    assign illegal_op = ill_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized scoreboard bench for alu_exec_unit: a driver pushes expected
// responses from an arithmetic reference model, a monitor pops and compares.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int W  = DW + 3;
    localparam longint MAX_POS = 64'sd2147483647;
    localparam longint MIN_NEG = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_op = '0;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic [SW-1:0] shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] result;
    logic          zero;
    logic          overflow;
    logic          illegal_op;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    logic seen_valid = 1'b0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    int           acc_q[$];

    alu_exec_unit #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a_data(a_data), .b_data(b_data), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .overflow(overflow), .illegal_op(illegal_op),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [SW-1:0] sh);
        logic [DW-1:0] r;
        logic ov;
        logic il;
        longint s;
        r = '0; ov = 1'b0; il = 1'b0; s = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = ~(a | b);
            4'd3: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                r  = s[DW-1:0];
                ov = (s > MAX_POS) || (s < MIN_NEG);
            end
            4'd4: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                r  = s[DW-1:0];
                ov = (s > MAX_POS) || (s < MIN_NEG);
            end
            4'd5: r = {b[15:0], 16'h0000};
            4'd6: r = b << sh;
            4'd7: r = b >> sh;
            default: il = 1'b1;
        endcase
        return {il, ov, (r == '0), r};
    endfunction

    function automatic int model_lat(input logic [3:0] op, input logic [SW-1:0] sh);
        if ((op == 4'd6 || op == 4'd7) && sh != 0) return int'(sh) + 1;
        return 1;
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [SW-1:0] sh, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; alu_op = op; a_data = a; b_data = b; shamt = sh;
        while (!ok && waited < 500) begin
            @(negedge clk);
            waited++;
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
        end else begin
            exp_q.push_back(model(op, a, b, sh));
            lat_q.push_back(model_lat(op, sh));
            acc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op = 4'($urandom); a_data = $urandom; b_data = $urandom; shamt = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete(); lat_q.delete(); acc_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                checks++;
                if (in_ready) begin
                    errors++;
                    $display("FAIL busy_ready: in_ready=%0b while out_valid, required 0", in_ready);
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: out_valid=1 with no operation outstanding");
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        checks++;
                        if (cyc - acc_q[0] != lat_q[0]) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles, required %0d", cyc - acc_q[0], lat_q[0]);
                        end
                    end
                    if (out_ready) begin
                        exp = exp_q.pop_front();
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                        seen_valid = 1'b0;
                        act = {illegal_op, overflow, zero, result};
                        checks++;
                        if (act !== exp) begin
                            errors++;
                            $display("FAIL result: got ill=%0b ovf=%0b zero=%0b res=%h, required ill=%0b ovf=%0b zero=%0b res=%h",
                                     act[W-1], act[W-2], act[W-3], act[DW-1:0],
                                     exp[W-1], exp[W-2], exp[W-3], exp[DW-1:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    initial begin
        int w;
        int n;
        logic [W-1:0] stall_exp;
        logic [3:0] op;
        int r;

        // reset state
        repeat (2) @(negedge clk);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_out_valid", out_valid, 1'b0);
        check_bit("reset_zero", zero, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        check_bit("reset_illegal", illegal_op, 1'b0);
        check_bit("reset_result", result == '0, 1'b1);
        reset = 1'b0;

        // directed cases
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
        issue(OP_SUB, 32'h1234_5678, 32'h1234_5678, 5'd0, w);
        issue(OP_LUI, 32'h0, 32'h0000_ABCD, 5'd0, w);
        issue(OP_SLL, 32'h0, 32'h1, 5'd4, w);
        issue(OP_SRL, 32'h0, 32'h8000_0000, 5'd31, w);
        issue(OP_SLL, 32'h0, 32'h1, 5'd31, w);
        issue(OP_SLL, 32'h0, 32'hDEAD_BEEF, 5'd0, w);
        issue(OP_ILLEGAL, 32'h5, 32'h7, 5'd3, w);
        issue(OP_NOR, 32'h0, 32'h0, 5'd0, w);
        issue(OP_SUB, 32'h8000_0000, 32'h1, 5'd0, w);
        drain();

        // stall in DONE for 10 cycles, with a competing request on the input side
        rdy_mode = 2;
        stall_exp = model(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0);
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0, w);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; alu_op = OP_OR; a_data = $urandom; b_data = $urandom;
            @(negedge clk);
            checks++;
            if ({illegal_op, overflow, zero, result} !== stall_exp || !out_valid || in_ready) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b rdy=%0b res=%h ovf=%0b, required v=1 rdy=0 res=%h ovf=%0b",
                         out_valid, in_ready, result, overflow, stall_exp[DW-1:0], stall_exp[W-2]);
            end
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, w);
        checks++;
        if (w != 2) begin
            errors++;
            $display("FAIL release_accept: accepted after %0d cycles, required 2", w);
        end
        drain();

        // asynchronous reset in the middle of a long shift
        issue(OP_SLL, 32'h0, 32'h1, 5'd20, w);
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_bit("async_out_valid", out_valid, 1'b0);
        check_bit("async_in_ready", in_ready, 1'b1);
        check_bit("async_result", result == '0, 1'b1);
        exp_q.delete(); lat_q.delete(); acc_q.delete();
        seen_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        issue(OP_ADD, 32'd2, 32'd3, 5'd0, w);
        drain();

        // randomized traffic with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       op = 4'(r);
            else if (r == 8) op = OP_ILLEGAL;
            else             op = 4'($urandom_range(8, 15));
            issue(op, $urandom, $urandom, 5'($urandom_range(0, 31)), w);
        end
        drain();
        rdy_mode = 0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, plus operands from the register file and immediate path.
- Single-cycle logic and arithmetic ops complete in one cycle; SLL/SRL iterate one bit per cycle by shamt.
- Valid/ready handshake on both sides, so the multicycle datapath controller can stall on it.
- Produces result, zero flag (feeds BEQ/BNE), signed overflow and illegal-op flags.

Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width (log2 DATA_WIDTH)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept (high only in IDLE)
- alu_op  in  4  operation code: 0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 LUI, 6 SLL, 7 SRL; any other value is illegal (decoder default is 9)
- a_data  in  DATA_WIDTH  operand A (rs)
- b_data  in  DATA_WIDTH  operand B (rt or extended immediate)
- shamt  in  SHAMT_WIDTH  shift amount, used by SLL/SRL only
- out_valid  out  1  result registers hold a completed operation
- out_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow on ADD/SUB, else 0
- illegal_op  out  1  alu_op was not a defined code

Behaviour:
- FSM states: IDLE, SHIFT, DONE. Reset (async, any state, including mid-shift) forces IDLE. Reset values: in_ready=1, out_valid=0, result=0, zero=0, overflow=0, illegal_op=0, shift counter=0. Any in-flight operation is discarded.
- Accept: a transfer occurs on the edge where in_valid & in_ready. Operands, op and shamt are captured at that edge; later input changes are ignored.
- Non-shift op (or shamt=0): result computed and registered at the accept edge; state goes to DONE. out_valid is high the next cycle (latency 1).
- AND/OR/NOR: bitwise on A, B.
- ADD/SUB: A±B modulo 2^DATA_WIDTH. overflow = operand signs match (B inverted for SUB) and result sign differs.
- LUI: result = {B[15:0], 16'h0000}.
- Illegal code: result=0, zero=1, illegal_op=1, latency 1.
- SLL/SRL with shamt=k>0: at the accept edge B is loaded into the result register and counter=k; state goes to SHIFT. Each SHIFT cycle shifts the result by 1 (SLL left, SRL logical right, zero fill) and decrements the counter. After the edge that applies the k-th shift, state goes to DONE. out_valid is first high k+1 cycles after accept.
- in_ready=0 throughout SHIFT and DONE.
- zero is updated together with result; it is meaningful only while out_valid=1.
- DONE: result, zero, overflow and illegal_op are held stable while out_valid=1 and out_ready=0 (indefinite stall). On an edge with out_ready=1 the state returns to IDLE and out_valid drops. No new accept occurs on that edge: back-to-back throughput is one op per 2 cycles minimum.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- shamt of 31 is legal: SLL of 1 gives 32'h8000_0000 after 32 cycles total.

Decomposition:
- Shared package:
  - ALU operation code constants (AND..SRL, ILLEGAL=9), matching the ALU control decoder's encoding.
  - FSM state enum.
  - DATA_WIDTH/SHAMT_WIDTH defaults.
- One natural sub-module: alu_exec_comb, purely combinational. It produces the single-cycle result plus overflow/illegal flags from (alu_op, A, B). The top level holds the FSM, shift counter and output registers.

Test Plan:
- ADD A=32'h7FFF_FFFF, B=1, out_ready=1 → out_valid 1 cycle after accept; result=32'h8000_0000, overflow=1, zero=0.
- SUB A=B=32'h1234_5678 (BEQ case) → result=0, zero=1, overflow=0, latency 1. LUI B=32'h0000_ABCD → result=32'hABCD_0000.
- SLL B=1, shamt=4 → in_ready low 5 cycles, out_valid 5 cycles after accept, result=32'h10. SRL B=32'h8000_0000, shamt=31 → result=1. SLL shamt=0 → latency 1, result=B.
- alu_op=9 → result=0, zero=1, illegal_op=1. NOR A=B=0 → result=32'hFFFF_FFFF.
- Stall: hold out_ready=0 for 10 cycles in DONE → result/flags unchanged, in_ready=0, new in_valid not accepted. Release → IDLE next edge; the next op is accepted the cycle after.
- Assert reset mid-SHIFT (shamt=20, after 7 cycles) → immediately (async) out_valid=0, in_ready=1, result=0. A following ADD 2+3 → result=5.
